// File: rtl/dsp_lane_unpack_if.sv
// Handshake bundle for dsp_lane_unpack: 48-bit P word in, one SIMD lane per beat out.
interface dsp_lane_unpack_if #(
   parameter int out_width = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [47:0]          in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [out_width-1:0] out_data;
   logic [1:0]           out_lane;
   logic                 out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_lane, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_lane, out_last
   );
endinterface

// File: rtl/dsp_lane_unpack.sv
// Splits a captured 48-bit DSP48E2 P word into lanes streamed one per beat.
// Define DSP_LANE_UNPACK_SIGN_EXT_EN to sign-extend lanes instead of zero-extending.
//
// state | meaning
// IDLE  | no word held, ready to capture
// SEND  | presenting lane `counter` of the held word
module dsp_lane_unpack #(
   parameter int lanes     = 4,
   parameter int out_width = 16
) (
   input  logic              clock,
   input  logic              reset,
   dsp_lane_unpack_if.slave  bus
);
   localparam int lane_width = 48 / lanes;

   if (!(lanes == 1 || lanes == 2 || lanes == 4)) begin : g_bad_lanes
      $error("dsp_lane_unpack: lanes must be 1, 2 or 4");
   end
   if (out_width < lane_width || out_width > 48) begin : g_bad_width
      $error("dsp_lane_unpack: out_width must lie in [48/lanes, 48]");
   end

   typedef enum logic {IDLE, SEND} state_t;

   state_t                state;
   logic [1:0]            counter;
   logic [47:0]           hold;
   logic [lane_width-1:0] lane_bits;
   logic [out_width-1:0]  lane_ext;
   logic                  last;
   logic                  sending;

   always_comb begin
      lane_bits = hold[int'(counter) * lane_width +: lane_width];
      last      = (counter == 2'(lanes - 1));
`ifdef DSP_LANE_UNPACK_SIGN_EXT_EN
      lane_ext  = out_width'($signed(lane_bits));
`else
      lane_ext  = out_width'(lane_bits);
`endif
   end

   // Outputs are forced quiet while reset is held, not just after the reset edge.
   assign sending       = reset && (state == SEND);
   assign bus.out_valid = sending;
   assign bus.out_data  = sending ? lane_ext : '0;
   assign bus.out_lane  = sending ? counter : 2'd0;
   assign bus.out_last  = sending && last;
   assign bus.in_ready  = reset && ((state == IDLE) || (sending && bus.out_ready && last));

   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= IDLE;
         counter <= 2'd0;
         hold    <= 48'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  hold    <= bus.in_data;
                  counter <= 2'd0;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (bus.out_ready) begin
                  if (!last) begin
                     counter <= counter + 2'd1;
                  end else if (bus.in_valid) begin
                     // Refill on the last beat keeps back-to-back words bubble-free.
                     hold    <= bus.in_data;
                     counter <= 2'd0;
                  end else begin
                     state   <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/dsp_lane_unpack.md
Name: dsp_lane_unpack

Overview:
- Consumer at the far end of the DSP datapath. It captures one 48-bit DSP48E2 P result through a valid/ready handshake.
- It streams the result out one SIMD lane per beat: four 12-bit lanes (FOUR12), two 24-bit lanes (TWO24) or one 48-bit lane (ONE48).
- It is the inverse of the operand packing on the DSP input side: there, narrow words are concatenated into 48 bits; here, 48 bits are split back into words for downstream logic.

Parameters:
- lanes, 4, number of SIMD lanes in the 48-bit word. Legal values are 1, 2, 4; any other value raises $error at elaboration.
- out_width, 16, width of out_data. Must satisfy 48/lanes <= out_width <= 48; otherwise $error at elaboration.
- Derived localparam: lane_width = 48/lanes.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream P word is valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  48  DSP P result.
- out_valid  out  1  out_data holds a valid lane.
- out_ready  in  1  downstream accepts the current lane.
- out_data  out  out_width  current lane, extended to out_width.
- out_lane  out  2  index of the current lane (0 = least significant).
- out_last  out  1  current lane is the final lane of the word.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state goes to IDLE; lane counter and held word are cleared to 0.
  - While reset is low: in_ready=0, out_valid=0, out_data=0, out_lane=0, out_last=0.
- State IDLE:
  - out_valid=0; in_ready=1.
  - When in_valid=1, in_data is captured into the hold register, the counter is set to 0 and the state moves to SEND.
- State SEND:
  - out_valid=1.
  - out_data = hold[counter*lane_width +: lane_width], extended to out_width (zero-extension by default).
  - out_lane = counter; out_last = (counter == lanes-1).
- Lane handshake:
  - A beat completes when out_valid && out_ready.
  - If not last: counter increments and the state stays SEND.
  - If last and in_valid=1: the new word is captured, counter goes to 0 and the state stays SEND, giving back-to-back words with no bubble.
  - If last and in_valid=0: the state goes to IDLE.
- in_ready:
  - in_ready = (state==IDLE) || (state==SEND && out_ready && out_last).
  - Combinational from state and out_ready; it never depends on in_valid.
- Latency and throughput:
  - A word accepted at edge N presents lane 0 in the cycle after edge N.
  - Sustained throughput is one lane per cycle, i.e. one word every `lanes` cycles.
- Stability: while out_valid=1 and out_ready=0, out_data, out_lane and out_last hold constant, and the hold register is not overwritten.
- lanes=1: every word is a single beat with out_last=1 and out_lane=0. Upper out_data bits beyond 48 do not exist because out_width is at most 48.
- Reset asserted mid-word: remaining lanes are discarded and no partial word is emitted after reset releases.
- Simultaneous last-beat acceptance and new input is legal and expected; see the lane-handshake rule above.
- Stateless aside from the hold register, counter and state; no FIFO depth beyond one word.

Optional Feature:
- Macro: DSP_LANE_UNPACK_SIGN_EXT_EN.
- When defined: each lane is sign-extended from its top bit (bit lane_width-1) to out_width.
- When undefined: each lane is zero-extended.
- No port or timing differences between the two builds.

Test Plan:
- Basic split: lanes=4, out_width=16, in_data=48'h123456789ABC, out_ready=1. Beats must be:
  - 16'h0ABC, lane 0, last 0
  - 16'h0789, lane 1, last 0
  - 16'h0456, lane 2, last 0
  - 16'h0123, lane 3, last 1
  - Lane 0 appears the cycle after acceptance.
- Sign extension: same stimulus with DSP_LANE_UNPACK_SIGN_EXT_EN defined → 16'hFABC, 16'h0789, 16'h0456, 16'h0123.
- Backpressure: hold out_ready=0 for 3 cycles during lane 1 → out_data stays 16'h0789, in_ready=0 throughout; the remaining lanes follow unchanged after release.
- Back-to-back: lanes=2, out_width=24, words 48'hAAAAAA555555 then 48'h000001FFFFFE with in_valid held high.
  - Output: 24'h555555, 24'hAAAAAA, 24'hFFFFFE, 24'h000001 on 4 consecutive cycles.
  - in_ready=1 only on the last-lane cycles.
- Reset mid-word: lanes=4, drop reset to 0 after lane 1.
  - out_valid=0 and in_ready=0 while reset is low.
  - After release: in_ready=1 and no lanes 2/3 are emitted.
  - The next word 48'h000000000001 yields 16'h0001, 0, 0, 0.
- ONE48: lanes=1, out_width=48, in_data=48'hFEDCBA987654 → single beat with out_data=48'hFEDCBA987654, out_last=1, out_lane=0.
